uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART transmitter with a valid/ready byte interface.
//
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles. A byte offered in the final
// stop-bit cycle is accepted there, so back-to-back frames have no idle gap.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit before the stop
// bit (even parity when PARITY_ODD = 0, odd when 1). Without the macro there is
// no parity state or logic and PARITY_ODD has no effect.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (1..65535)
//   PARITY_ODD    parity sense, 0 even / 1 odd (parity builds only)
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   data_in     byte to send, latched when data_valid && ready at a rising edge
//   data_valid  producer offers data_in
//   ready       combinational; high in idle and in the last stop-bit cycle
//   tx          registered serial line, idles high
//   bsy         high while a frame is on the line
//   tx_done     one-cycle pulse in the cycle after each frame's last stop-bit cycle

module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       bsy,
    output logic       tx_done
);

    if (CLKS_PER_BIT == 0 || CLKS_PER_BIT > 65535 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_transmitter: parameter out of range");
    end

    localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        bit_end = (cnt_q == LastCnt);
        ready   = (state_q == StIdle) || ((state_q == StStop) && bit_end);
        accept  = data_valid && ready;

        // Baud counter runs only while a frame is on the line and wraps at each bit end.
        if (state_q != StIdle) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        // tx is registered, so the value for the next bit is loaded on the edge
        // that leaves the current bit.
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Acceptance overrides the idle/stop handling above and starts a new frame.
        if (accept) begin
            state_d  = StStart;
            shift_d  = data_in;
            tx_d     = 1'b0;
            cnt_d    = 16'd0;
            idx_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_d = (^data_in) ^ (PARITY_ODD != 0);
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign bsy     = (state_q != StIdle);

endmodule
